move_collector: RTL and testbench

- Drains the per-square move FIFOs after a move-generation pass.
- Scans squares round-robin through an external FIFO mux, reads one 160-bit word at a time, and splits it into eight 19-bit move slots.
- Invalid slots are discarded. Valid moves go out one per handshake on a stream to the search/evaluation logic.
- Reports a finished flag and a move count once every square is done and every FIFO is empty.

---
 rtl/move_collector.sv | 163 ++++++++++++++++
 tb/tb_move_collector.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_collector.sv
// move_collector
//   After a move-generation pass, walks the per-square move FIFOs round-robin
//   through an external mux, reads one 160-bit word at a time, and streams the
//   valid 19-bit slots of each word out as 18-bit moves, one per handshake.
//   When every square reports done and every FIFO is empty, the pass ends with
//   finished=1 and mv_count holding the number of moves emitted (saturating).
//
// Ports
//   clk       in   clock
//   reset     in   asynchronous active-low reset
//   start     in   one-cycle pulse, begins a pass (honoured in IDLE and FIN)
//   sq_done   in   [NUM_SQ]  per-square generation-done flags
//   sq_empty  in   [NUM_SQ]  per-square FIFO empty flags
//   sq_sel    out  [SEL_W]   square whose FIFO q/rdreq are muxed to us
//   rden      out  read request to the selected FIFO
//   fifo_q    in   [160]     selected FIFO word, valid the cycle after rden
//   mv_data   out  [18]      {promote,pawn,pawn2,ep,castle,capture,from,to}
//   mv_valid  out  mv_data valid
//   mv_ready  in   downstream accept
//   busy      out  pass in progress
//   finished  out  pass complete, held until the next start
//   mv_count  out  [CNT_W]   moves emitted this pass, saturating
module move_collector #(
  parameter int NUM_SQ = 64,
  parameter int SEL_W  = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_SQ-1:0] sq_done,
  input  logic [NUM_SQ-1:0] sq_empty,
  output logic [SEL_W-1:0]  sq_sel,
  output logic              rden,
  input  logic [159:0]      fifo_q,
  output logic [17:0]       mv_data,
  output logic              mv_valid,
  input  logic              mv_ready,
  output logic              busy,
  output logic              finished,
  output logic [CNT_W-1:0]  mv_count
);

  localparam int SLOTS  = 8;
  localparam int SLOT_W = 19;
  localparam int WORD_W = SLOTS * SLOT_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_READ,
    S_WAIT,
    S_UNPK,
    S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [SLOTS-1:0]    mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          pick;
  logic                all_drained;
  logic                unused_fifo_hi;

  // Saturating increment of the move counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Index of the lowest set mask bit; invalid slots are skipped in zero cycles.
  function automatic logic [2:0] first_set(input logic [SLOTS-1:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if (m[k]) idx = 3'(k);
    end
    return idx;
  endfunction

  assign pick           = first_set(mask_q);
  assign all_drained    = (&sq_done) & (&sq_empty);
  // The top byte of the FIFO word carries no slot.
  assign unused_fifo_hi = ^fifo_q[159:WORD_W];

  assign sq_sel   = sel_q;
  assign mv_count = cnt_q;
  assign busy     = (state_q == S_SCAN) || (state_q == S_READ) ||
                    (state_q == S_WAIT) || (state_q == S_UNPK);
  assign finished = (state_q == S_FIN);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    word_d   = word_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    rden     = 1'b0;
    mv_valid = (state_q == S_UNPK) && (mask_q != '0);
    mv_data  = mv_valid ? word_q[SLOT_W * int'(pick) +: 18] : '0;

    case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          state_d = S_SCAN;
          sel_d   = '0;
          cnt_d   = '0;
        end
      end
      S_SCAN: begin
        if (all_drained) begin
          state_d = S_FIN;
        end else if (!sq_empty[sel_q]) begin
          state_d = S_READ;
        end else begin
          sel_d = (sel_q == SEL_W'(NUM_SQ - 1)) ? '0 : sel_q + 1'b1;
        end
      end
      S_READ: begin
        // Guarded so an empty FIFO is never popped.
        rden    = ~sq_empty[sel_q];
        state_d = S_WAIT;
      end
      S_WAIT: begin
        word_d = fifo_q[WORD_W-1:0];
        for (int k = 0; k < SLOTS; k++) begin
          mask_d[k] = ~fifo_q[SLOT_W * k + SLOT_W - 1];
        end
        state_d = S_UNPK;
      end
      S_UNPK: begin
        // Stay on the same square: it may hold further words.
        if (mask_q == '0) begin
          state_d = S_SCAN;
        end else if (mv_ready) begin
          mask_d[pick] = 1'b0;
          cnt_d        = sat_inc(cnt_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  // Word payload needs no reset; the mask qualifies it.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

endmodule

// File: tb/tb_move_collector.sv
module tb_move_collector;
  localparam int NSQ = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, start_a, start_b, mv_ready, use_b;
  logic [NSQ-1:0]  sq_done, sq_empty;
  logic [159:0]    fifo_q;
  logic [5:0]      sel_a, sel_b, sel_m;
  logic            rden_a, rden_b, rden_m;
  logic [17:0]     data_a, data_b, data_m;
  logic            valid_a, valid_b, valid_m;
  logic            busy_a, busy_b, busy_m;
  logic            fin_a, fin_b, fin_m;
  logic [7:0]      cnt_a;
  logic [2:0]      cnt_b;

  move_collector #(.NUM_SQ(64), .SEL_W(6), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start_a), .sq_done(sq_done),
    .sq_empty(sq_empty), .sq_sel(sel_a), .rden(rden_a), .fifo_q(fifo_q),
    .mv_data(data_a), .mv_valid(valid_a), .mv_ready(mv_ready),
    .busy(busy_a), .finished(fin_a), .mv_count(cnt_a));

  move_collector #(.NUM_SQ(64), .SEL_W(6), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .start(start_b), .sq_done(sq_done),
    .sq_empty(sq_empty), .sq_sel(sel_b), .rden(rden_b), .fifo_q(fifo_q),
    .mv_data(data_b), .mv_valid(valid_b), .mv_ready(mv_ready),
    .busy(busy_b), .finished(fin_b), .mv_count(cnt_b));

  // The FIFO model serves whichever collector owns the pass.
  assign sel_m   = use_b ? sel_b   : sel_a;
  assign rden_m  = use_b ? rden_b  : rden_a;
  assign data_m  = use_b ? data_b  : data_a;
  assign valid_m = use_b ? valid_b : valid_a;
  assign busy_m  = use_b ? busy_b  : busy_a;
  assign fin_m   = use_b ? fin_b   : fin_a;

  // Per-square FIFO model: registered output, one cycle read latency.
  logic [159:0] mem [NSQ][16];
  int wr_ptr [NSQ];
  int rd_ptr [NSQ] = '{default: 0};
  logic [159:0] ref_q [NSQ][$];

  always_comb begin
    for (int i = 0; i < NSQ; i++) sq_empty[i] = (wr_ptr[i] == rd_ptr[i]);
  end

  always @(posedge clk) begin
    if (rden_m && (wr_ptr[sel_m] != rd_ptr[sel_m])) begin
      fifo_q <= mem[sel_m][rd_ptr[sel_m] % 16];
      rd_ptr[sel_m] <= rd_ptr[sel_m] + 1;
    end
  end

  // Observation of the stream and read requests, away from the active edge.
  logic [17:0] got[$];
  logic [17:0] exp_mv[$];
  int rd_sel[$];
  int bad_rd, prev_sel;
  bit saw_wrap;
  int n_checks = 0, n_pass = 0;

  always @(negedge clk) begin
    if (valid_m && mv_ready) got.push_back(data_m);
    if (rden_m) begin
      rd_sel.push_back(int'(sel_m));
      if (sq_empty[sel_m]) bad_rd++;
    end
    if (reset && busy_m && prev_sel == 63 && sel_m == 0) saw_wrap = 1'b1;
    prev_sel = int'(sel_m);
  end

  function automatic logic [18:0] mk_slot(input bit valid, input logic [17:0] d);
    return {~valid, d};
  endfunction

  task automatic load(input int sq, input logic [159:0] w);
    mem[sq][wr_ptr[sq] % 16] = w;
    wr_ptr[sq] = wr_ptr[sq] + 1;
    ref_q[sq].push_back(w);
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < NSQ; i++) begin
      wr_ptr[i] = rd_ptr[i];
      ref_q[i].delete();
    end
  endtask

  // Reference: squares drained from 0 upward, words in FIFO order, valid
  // slots in ascending index order.
  task automatic build_expected();
    exp_mv.delete();
    for (int s = 0; s < NSQ; s++) begin
      foreach (ref_q[s][j]) begin
        for (int k = 0; k < 8; k++) begin
          if (!ref_q[s][j][19*k+18]) exp_mv.push_back(ref_q[s][j][19*k +: 18]);
        end
      end
      ref_q[s].delete();
    end
  endtask

  function automatic int first_diff();
    if (got.size() != exp_mv.size()) return -2;
    foreach (got[i]) if (got[i] !== exp_mv[i]) return i;
    return -1;
  endfunction

  function automatic logic [159:0] rand_word(input int valid_mode);
    logic [159:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 8; k++) begin
      bit v;
      v = (valid_mode == 1) ? 1'b1 : (valid_mode == 0) ? 1'b0 : bit'($urandom_range(0, 1));
      w[19*k +: 19] = mk_slot(v, 18'($urandom));
    end
    return w;
  endfunction

  task automatic pulse_start();
    got.delete();
    rd_sel.delete();
    @(posedge clk); #1;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_fin(input int budget, input bit rnd_ready, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (fin_m) begin
        timed_out = 1'b0;
        break;
      end
      mv_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  logic [159:0] w5;

  task automatic test_reset();
    int rd_seen;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({sel_a, rden_a, valid_a, data_a, busy_a, fin_a, cnt_a} !== '0)
      $display("FAIL reset_outputs got sel=%0d rden=%b vld=%b data=%h busy=%b fin=%b cnt=%0d want all 0",
               sel_a, rden_a, valid_a, data_a, busy_a, fin_a, cnt_a);
    else n_pass++;
    reset = 1'b1;
    rd_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rden_a) rd_seen++;
    end
    n_checks++;
    if (rd_seen !== 0) $display("FAIL idle_no_rden got %0d rden cycles want 0", rd_seen);
    else n_pass++;
    n_checks++;
    if ({busy_a, fin_a} !== 2'b00) $display("FAIL idle_flags got busy=%b fin=%b want 0 0", busy_a, fin_a);
    else n_pass++;
  endtask

  task automatic test_single();
    bit to;
    logic [17:0] g0;
    w5 = rand_word(0);
    w5[0 +: 19]  = mk_slot(1'b1, {12'($urandom), 6'o25});
    w5[57 +: 19] = mk_slot(1'b1, {12'($urandom), 6'o37});
    clear_fifos();
    load(5, w5);
    build_expected();
    bad_rd = 0;
    mv_ready = 1'b1;
    pulse_start();
    wait_fin(300, 1'b0, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL single_timeout finished never rose");
    else n_pass++;
    n_checks++;
    if (rd_sel.size() !== 1 || rd_sel[0] !== 5)
      $display("FAIL single_rden got %0d reads (first sel %0d) want 1 read at sel 5",
               rd_sel.size(), (rd_sel.size() > 0) ? rd_sel[0] : -1);
    else n_pass++;
    g0 = (got.size() > 0) ? got[0] : 'x;
    n_checks++;
    if (first_diff() !== -1 || g0[5:0] !== 6'o25)
      $display("FAIL single_moves got %0d moves first=%h want %0d moves first to=25o", got.size(), g0, exp_mv.size());
    else n_pass++;
    n_checks++;
    if (fin_a !== 1'b1 || cnt_a !== 8'd2 || busy_a !== 1'b0)
      $display("FAIL single_count got fin=%b cnt=%0d busy=%b want 1 2 0", fin_a, cnt_a, busy_a);
    else n_pass++;
  endtask

  task automatic test_stall();
    bit to, seen;
    int stall_bad;
    logic [17:0] d0;
    clear_fifos();
    load(5, w5);
    build_expected();
    mv_ready = 1'b0;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (valid_a) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    d0 = data_a;
    n_checks++;
    if (!seen || d0 !== exp_mv[0]) $display("FAIL stall_first got vld=%b data=%h want 1 %h", seen, d0, exp_mv[0]);
    else n_pass++;
    stall_bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (valid_a !== 1'b1 || data_a !== d0) stall_bad++;
    end
    n_checks++;
    if (stall_bad !== 0) $display("FAIL stall_hold got %0d unstable cycles want 0", stall_bad);
    else n_pass++;
    mv_ready = 1'b1;
    wait_fin(300, 1'b0, to);
    n_checks++;
    if (to !== 1'b0 || first_diff() !== -1 || cnt_a !== 8'd2)
      $display("FAIL stall_moves got to=%b moves=%0d cnt=%0d want 0 %0d 2", to, got.size(), cnt_a, exp_mv.size());
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit to;
    clear_fifos();
    load(63, rand_word(1));
    load(63, rand_word(1));
    build_expected();
    bad_rd = 0;
    sq_done = '0;
    mv_ready = 1'b1;
    pulse_start();
    saw_wrap = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    sq_done = '1;
    wait_fin(300, 1'b0, to);
    n_checks++;
    if (to !== 1'b0 || saw_wrap !== 1'b1) $display("FAIL wrap_sel got to=%b wrap=%b want 0 1", to, saw_wrap);
    else n_pass++;
    n_checks++;
    if (first_diff() !== -1) $display("FAIL wrap_moves got %0d moves (diff %0d) want %0d", got.size(), first_diff(), exp_mv.size());
    else n_pass++;
    n_checks++;
    if (cnt_a !== 8'd16 || bad_rd !== 0 || rd_sel.size() !== 2)
      $display("FAIL wrap_count got cnt=%0d bad_rd=%0d reads=%0d want 16 0 2", cnt_a, bad_rd, rd_sel.size());
    else n_pass++;
  endtask

  task automatic test_saturate();
    bit to;
    logic [159:0] w;
    clear_fifos();
    load(10, rand_word(1));
    w = rand_word(0);
    w[38 +: 19]  = mk_slot(1'b1, 18'($urandom));
    w[114 +: 19] = mk_slot(1'b1, 18'($urandom));
    load(40, w);
    build_expected();
    use_b = 1'b1;
    pulse_start();
    wait_fin(2000, 1'b1, to);
    n_checks++;
    if (to !== 1'b0 || first_diff() !== -1 || exp_mv.size() !== 10)
      $display("FAIL sat_moves got to=%b moves=%0d want 0 10", to, got.size());
    else n_pass++;
    n_checks++;
    if (cnt_b !== 3'd7) $display("FAIL sat_count got %0d want 7", cnt_b);
    else n_pass++;
    use_b = 1'b0;
    mv_ready = 1'b1;
  endtask

  task automatic test_random();
    bit to;
    int nw, exp_cnt;
    for (int r = 0; r < 4; r++) begin
      clear_fifos();
      nw = $urandom_range(1, 6);
      for (int j = 0; j < nw; j++) load($urandom_range(0, NSQ - 1), rand_word(2));
      build_expected();
      exp_cnt = (exp_mv.size() > 255) ? 255 : exp_mv.size();
      bad_rd = 0;
      pulse_start();
      wait_fin(3000, 1'b1, to);
      n_checks++;
      if (to !== 1'b0 || first_diff() !== -1 || int'(cnt_a) !== exp_cnt || bad_rd !== 0 || rd_sel.size() !== nw)
        $display("FAIL random_%0d got to=%b moves=%0d cnt=%0d bad_rd=%0d reads=%0d want 0 %0d %0d 0 %0d",
                 r, to, got.size(), cnt_a, bad_rd, rd_sel.size(), exp_mv.size(), exp_cnt, nw);
      else n_pass++;
      mv_ready = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    bit to, seen;
    logic [159:0] w;
    clear_fifos();
    w = rand_word(0);
    for (int k = 1; k < 4; k++) w[19*k +: 19] = mk_slot(1'b1, 18'($urandom));
    load(7, w);
    build_expected();
    mv_ready = 1'b1;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (valid_a) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    mv_ready = 1'b0;
    n_checks++;
    if (!seen || valid_a !== 1'b1 || cnt_a !== 8'd1)
      $display("FAIL mid_pre got seen=%b vld=%b cnt=%0d want 1 1 1", seen, valid_a, cnt_a);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({valid_a, busy_a, rden_a, fin_a, cnt_a, data_a} !== '0)
      $display("FAIL mid_reset got vld=%b busy=%b rden=%b fin=%b cnt=%0d data=%h want all 0",
               valid_a, busy_a, rden_a, fin_a, cnt_a, data_a);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    mv_ready = 1'b1;
    clear_fifos();
    load(2, rand_word(2));
    build_expected();
    pulse_start();
    n_checks++;
    if (sel_a !== 6'd0 || busy_a !== 1'b1) $display("FAIL mid_restart got sel=%0d busy=%b want 0 1", sel_a, busy_a);
    else n_pass++;
    wait_fin(300, 1'b0, to);
    n_checks++;
    if (to !== 1'b0 || first_diff() !== -1 || int'(cnt_a) !== exp_mv.size())
      $display("FAIL mid_rescan got to=%b moves=%0d cnt=%0d want 0 %0d %0d", to, got.size(), cnt_a, exp_mv.size(), exp_mv.size());
    else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    mv_ready = 1'b0;
    use_b = 1'b0;
    sq_done = '1;
    bad_rd = 0;
    prev_sel = 0;
    saw_wrap = 1'b0;
    for (int i = 0; i < NSQ; i++) wr_ptr[i] = 0;
    test_reset();
    test_single();
    test_stall();
    test_wrap();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
